// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared KNN types: sequencer states and K-select encodings
package knn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_VOTE   = 3'd4,
        ST_RESULT = 3'd5
    } knn_state_t;

    localparam logic [1:0] K1 = 2'b00;
    localparam logic [1:0] K3 = 2'b01;
    localparam logic [1:0] K5 = 2'b10;

    // The unused 2'b11 code selects the largest supported K.
    function automatic logic [1:0] map_k(input logic [1:0] k);
        return (k == 2'b11) ? K5 : k;
    endfunction

endpackage

// File: rtl/knn_tag_delay.sv
// rtl/knn_tag_delay.sv - fixed-depth delay line for read tags, with synchronous flush
module knn_tag_delay #(
    parameter int DEPTH    = 1,
    parameter int W        = 3,
    parameter int LAST_BIT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         pending
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

    // Any last-feature tag still in flight means a sample has not reached the sorter yet.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pending = pending | stage[i][LAST_BIT];
        end
    end

endmodule

// File: rtl/knn_query_sequencer.sv
// rtl/knn_query_sequencer.sv - per-query controller: clear, stream features, sort strobes, vote
module knn_query_sequencer
    import knn_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int FEAT_W  = 3,
    parameter int MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     RESETn,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        n_train,
    input  logic [1:0]               k_sel,
    input  logic                     abort,
    output logic                     mem_rd_en,
    output logic [ADDR_W+FEAT_W-1:0] mem_addr,
    output logic                     dist_acc_en,
    output logic                     dist_first,
    output logic                     dist_last,
    output logic                     new_start,
    output logic                     sort_en,
    output logic                     vote_en,
    output logic [1:0]               K_control,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = ADDR_W + FEAT_W;
    localparam logic [FEAT_W-1:0] FEAT_LAST = '1;
    localparam logic [AW-1:0]     ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    knn_state_t        state;
    logic [ADDR_W-1:0] n_train_q;
    logic [AW-1:0]     last_addr;
    logic [FEAT_W-1:0] feat_idx;
    logic [2:0]        tag_in;
    logic [2:0]        tag_out;
    logic              flush;
    logic              last_pending;

    assign last_addr = {n_train_q, FEAT_LAST};
    assign feat_idx  = mem_addr[FEAT_W-1:0];
    assign flush     = abort && (state != ST_IDLE);

    assign tag_in = {mem_rd_en,
                     mem_rd_en && (feat_idx == '0),
                     mem_rd_en && (feat_idx == FEAT_LAST)};

    knn_tag_delay #(
        .DEPTH    (MEM_LAT),
        .W        (3),
        .LAST_BIT (0)
    ) u_tag_delay (
        .clk     (clk),
        .rst_n   (RESETn),
        .flush   (flush),
        .din     (tag_in),
        .dout    (tag_out),
        .pending (last_pending)
    );

    assign {dist_acc_en, dist_first, dist_last} = tag_out;

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state     <= ST_IDLE;
            n_train_q <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            new_start <= 1'b0;
            sort_en   <= 1'b0;
            vote_en   <= 1'b0;
            K_control <= K1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            new_start <= 1'b0;
            vote_en   <= 1'b0;
            done      <= 1'b0;
            sort_en   <= dist_last && !flush;
            if (flush) begin
                state     <= ST_IDLE;
                mem_rd_en <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            n_train_q <= n_train;
                            K_control <= map_k(k_sel);
                            new_start <= 1'b1;
                            busy      <= 1'b1;
                            mem_addr  <= '0;
                            state     <= ST_CLEAR;
                        end
                    end
                    ST_CLEAR: begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= '0;
                        state     <= ST_STREAM;
                    end
                    ST_STREAM: begin
                        // Compare before incrementing so a full-range n_train never wraps the address.
                        if (mem_addr == last_addr) begin
                            mem_rd_en <= 1'b0;
                            state     <= ST_DRAIN;
                        end else begin
                            mem_addr <= mem_addr + ADDR_ONE;
                        end
                    end
                    ST_DRAIN: begin
                        if (sort_en && !last_pending) begin
                            vote_en <= 1'b1;
                            state   <= ST_VOTE;
                        end
                    end
                    ST_VOTE: begin
                        done  <= 1'b1;
                        state <= ST_RESULT;
                    end
                    ST_RESULT: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_knn_query_sequencer.sv
// tb/tb_knn_query_sequencer.sv - directed self-checking bench for knn_query_sequencer
module tb_knn_query_sequencer;

    logic        clk = 1'b0;
    logic        RESETn;
    logic        start, abort;
    logic [7:0]  n_train;
    logic [1:0]  k_sel;
    logic        mem_rd_en, dist_acc_en, dist_first, dist_last;
    logic [10:0] mem_addr;
    logic        new_start, sort_en, vote_en, busy, done;
    logic [1:0]  K_control;

    logic        start_b, abort_b;
    logic [7:0]  n_train_b;
    logic [1:0]  k_sel_b;
    logic        mem_rd_en_b, dist_acc_en_b, dist_first_b, dist_last_b;
    logic [10:0] mem_addr_b;
    logic        new_start_b, sort_en_b, vote_en_b, busy_b, done_b;
    logic [1:0]  K_control_b;

    always #5 clk = ~clk;

    knn_query_sequencer #(.ADDR_W(8), .FEAT_W(3), .MEM_LAT(1)) dut_a (
        .clk(clk), .RESETn(RESETn), .start(start), .n_train(n_train), .k_sel(k_sel),
        .abort(abort), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .dist_acc_en(dist_acc_en),
        .dist_first(dist_first), .dist_last(dist_last), .new_start(new_start), .sort_en(sort_en),
        .vote_en(vote_en), .K_control(K_control), .busy(busy), .done(done)
    );

    knn_query_sequencer #(.ADDR_W(8), .FEAT_W(3), .MEM_LAT(3)) dut_b (
        .clk(clk), .RESETn(RESETn), .start(start_b), .n_train(n_train_b), .k_sel(k_sel_b),
        .abort(abort_b), .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b), .dist_acc_en(dist_acc_en_b),
        .dist_first(dist_first_b), .dist_last(dist_last_b), .new_start(new_start_b), .sort_en(sort_en_b),
        .vote_en(vote_en_b), .K_control(K_control_b), .busy(busy_b), .done(done_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rd_cnt = 0, rd_first = 0, rd_last = 0, rd_rises = 0, addr_err = 0;
    int first_cnt = 0, last_cnt = 0, sort_cnt = 0, vote_cnt = 0, vote_last = 0;
    int done_cnt = 0, done_last = 0, ns_cnt = 0, ns_last = 0;
    int sort_q[$];
    logic rd_prev = 1'b0;
    logic [10:0] exp_addr = '0;

    always @(negedge clk) begin
        if (mem_rd_en) begin
            if (!rd_prev) begin
                rd_rises <= rd_rises + 1;
                rd_first <= cyc;
                if (mem_addr !== 11'd0) addr_err <= addr_err + 1;
            end else if (mem_addr !== exp_addr) begin
                addr_err <= addr_err + 1;
            end
            exp_addr <= mem_addr + 11'd1;
            rd_cnt   <= rd_cnt + 1;
            rd_last  <= cyc;
        end
        rd_prev <= mem_rd_en;
        if (dist_acc_en && dist_first) first_cnt <= first_cnt + 1;
        if (dist_acc_en && dist_last)  last_cnt  <= last_cnt + 1;
        if (sort_en) begin
            sort_cnt <= sort_cnt + 1;
            sort_q.push_back(cyc);
        end
        if (vote_en) begin
            vote_cnt  <= vote_cnt + 1;
            vote_last <= cyc;
        end
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_last <= cyc;
        end
        if (new_start) begin
            ns_cnt  <= ns_cnt + 1;
            ns_last <= cyc;
        end
    end

    int rd_cnt_b = 0, rises_b = 0, addr_err_b = 0, sort_cnt_b = 0, done_last_b = 0;
    logic rd_prev_b = 1'b0;
    logic [10:0] exp_addr_b = '0, last_addr_b = '0;

    always @(negedge clk) begin
        if (mem_rd_en_b) begin
            if (!rd_prev_b) begin
                rises_b <= rises_b + 1;
                if (mem_addr_b !== 11'd0) addr_err_b <= addr_err_b + 1;
            end else if (mem_addr_b !== exp_addr_b) begin
                addr_err_b <= addr_err_b + 1;
            end
            exp_addr_b  <= mem_addr_b + 11'd1;
            last_addr_b <= mem_addr_b;
            rd_cnt_b    <= rd_cnt_b + 1;
        end
        rd_prev_b <= mem_rd_en_b;
        if (sort_en_b) sort_cnt_b <= sort_cnt_b + 1;
        if (done_b) done_last_b <= cyc;
    end

    int errors = 0, checks = 0;
    int t;
    int b_rd, b_rises, b_err, b_first, b_last, b_sort, b_vote, b_done, b_ns;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        b_rd = rd_cnt; b_rises = rd_rises; b_err = addr_err; b_first = first_cnt;
        b_last = last_cnt; b_sort = sort_cnt; b_vote = vote_cnt; b_done = done_cnt; b_ns = ns_cnt;
    endtask

    task automatic start_query(input logic [7:0] n, input logic [1:0] k);
        snap();
        start = 1'b1; n_train = n; k_sel = k; t = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic step_to(input int c);
        int guard = 0;
        while (cyc < c && guard < 1000) begin
            step();
            guard++;
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
    endtask

    task automatic verify(input string tag, input int n_smp, input int exp_done, input logic [1:0] kexp);
        check({tag, "_new_start_cycle"}, ns_last - t, 1);
        check({tag, "_new_start_count"}, ns_cnt - b_ns, 1);
        check({tag, "_read_count"}, rd_cnt - b_rd, n_smp * 8);
        check({tag, "_first_read"}, rd_first - t, 2);
        check({tag, "_last_read"}, rd_last - t, exp_done - 4);
        check({tag, "_read_bursts"}, rd_rises - b_rises, 1);
        check({tag, "_addr_errors"}, addr_err - b_err, 0);
        check({tag, "_dist_first_count"}, first_cnt - b_first, n_smp);
        check({tag, "_dist_last_count"}, last_cnt - b_last, n_smp);
        check({tag, "_sort_count"}, sort_cnt - b_sort, n_smp);
        for (int i = 0; i < n_smp; i++) begin
            check({tag, "_sort_cycle"}, (b_sort + i < sort_q.size()) ? sort_q[b_sort + i] - t : -1, 11 + 8 * i);
        end
        check({tag, "_vote_count"}, vote_cnt - b_vote, 1);
        check({tag, "_vote_cycle"}, vote_last - t, exp_done - 1);
        check({tag, "_done_cycle"}, done_last - t, exp_done);
        check({tag, "_k_control"}, K_control, kexp);
        check({tag, "_busy_at_done"}, busy, 1);
        step();
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_done_after"}, done, 0);
    endtask

    initial begin
        RESETn = 1'b0; start = 1'b0; abort = 1'b0; n_train = '0; k_sel = '0;
        start_b = 1'b0; abort_b = 1'b0; n_train_b = '0; k_sel_b = '0;
        step(); step();
        check("reset_outputs",
              {mem_rd_en, mem_addr, dist_acc_en, dist_first, dist_last, new_start,
               sort_en, vote_en, K_control, busy, done}, 0);
        RESETn = 1'b1;
        step(); step();

        // 1: four samples, K3
        start_query(8'd3, 2'b01);
        wait_done("s1", 200);
        verify("s1", 4, 37, 2'b01);
        step();

        // 2: single sample, k_sel 11 maps to K5
        start_query(8'd0, 2'b11);
        wait_done("s2", 200);
        verify("s2", 1, 13, 2'b10);
        step();

        // 3: second start mid-stream is ignored
        start_query(8'd3, 2'b00);
        step_to(t + 10);
        start = 1'b1; n_train = 8'd0; k_sel = 2'b11;
        step();
        start = 1'b0;
        wait_done("s3", 200);
        verify("s3", 4, 37, 2'b00);
        step();

        // 4a: abort in STREAM, just before the first sort strobe
        start_query(8'd3, 2'b01);
        step_to(t + 10);
        check("s4a_streaming", mem_rd_en, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("s4a_busy_cleared", busy, 0);
        check("s4a_rd_stopped", mem_rd_en, 0);
        check("s4a_acc_flushed", dist_acc_en, 0);
        check("s4a_sort_flushed", sort_en, 0);
        b_rd = rd_cnt;
        for (int i = 0; i < 40; i++) step();
        check("s4a_no_more_reads", rd_cnt - b_rd, 0);
        check("s4a_no_sort", sort_cnt - b_sort, 0);
        check("s4a_no_vote", vote_cnt - b_vote, 0);
        check("s4a_no_done", done_cnt - b_done, 0);
        check("s4a_k_kept", K_control, 2'b01);

        // 4b: abort in DRAIN while the last tag is leaving the pipeline
        start_query(8'd0, 2'b00);
        step_to(t + 10);
        check("s4b_draining", {mem_rd_en, dist_last, busy}, 3'b011);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("s4b_busy_cleared", busy, 0);
        check("s4b_sort_flushed", sort_en, 0);
        for (int i = 0; i < 20; i++) step();
        check("s4b_no_sort", sort_cnt - b_sort, 0);
        check("s4b_no_vote", vote_cnt - b_vote, 0);
        check("s4b_no_done", done_cnt - b_done, 0);
        start_query(8'd3, 2'b01);
        wait_done("s4c", 200);
        verify("s4c", 4, 37, 2'b01);
        step();

        // 5: reset mid-stream, then start and abort together in IDLE
        start_query(8'd3, 2'b10);
        step_to(t + 10);
        RESETn = 1'b0;
        #1;
        check("s5_reset_outputs",
              {mem_rd_en, mem_addr, dist_acc_en, dist_first, dist_last, new_start,
               sort_en, vote_en, K_control, busy, done}, 0);
        step(); step();
        RESETn = 1'b1;
        snap();
        for (int i = 0; i < 20; i++) step();
        check("s5_idle_busy", busy, 0);
        check("s5_idle_reads", rd_cnt - b_rd, 0);
        check("s5_idle_new_start", ns_cnt - b_ns, 0);
        check("s5_idle_sort", sort_cnt - b_sort, 0);
        abort = 1'b1;
        start_query(8'd3, 2'b10);
        abort = 1'b0;
        check("s5_start_wins", busy, 1);
        wait_done("s5", 200);
        verify("s5", 4, 37, 2'b10);
        step();

        // 6: MEM_LAT=3, full 256-sample range
        start_b = 1'b1; n_train_b = 8'd255; k_sel_b = 2'b01; t = cyc;
        step();
        start_b = 1'b0;
        for (int n = 0; n < 3000 && done_b !== 1'b1; n++) step();
        check("s6_done_seen", done_b, 1);
        check("s6_read_count", rd_cnt_b, 2048);
        check("s6_read_bursts", rises_b, 1);
        check("s6_addr_errors", addr_err_b, 0);
        check("s6_last_addr", last_addr_b, 11'h7FF);
        check("s6_sort_count", sort_cnt_b, 256);
        check("s6_done_cycle", done_last_b - t, 2055);
        check("s6_k_control", K_control_b, 2'b01);
        step();
        check("s6_busy_after", busy_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
